// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register of the pipelined
// ARM core. It holds the program counter and drives the instruction-memory
// address. It captures the fetched word into IF/ID. It also enforces
// hazard-unit freezes and EXE branch squashes on the front of the pipe.
//
// Parameters
//   RESET_PC         PC loaded on reset (bits [1:0] must be zero)
//
// Ports
//   clk              pipeline clock, rising-edge
//   rst_n            asynchronous active-low reset
//   hazard_detected  freeze: PC and IF/ID hold
//   branch_taken     redirect: PC <= target, IF/ID flushed to a bubble
//   branch_address   redirect target (bits [1:0] ignored)
//   imem_addr        instruction-memory address (= PC register)
//   imem_rdata       instruction word, combinational from imem_addr
//   if_id_pc         PC+4 of the captured instruction
//   if_id_instr      captured instruction word
//   if_id_valid      captured instruction is real (0 = bubble)
//   fetch_state      0 RESET_FILL, 1 RUN, 2 STALL, 3 REDIRECT
//   stall_count      saturating freeze-cycle count   (STALL_COUNTER_EN)
//   flush_count      saturating redirect count       (STALL_COUNTER_EN)
//
// Build option
//   STALL_COUNTER_EN  when defined, adds the stall/flush counters and ports.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard_detected,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [1:0]  fetch_state
`ifdef STALL_COUNTER_EN
    ,
    output logic [31:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RESET_FILL = 2'd0,
        RUN        = 2'd1,
        STALL      = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_p0;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic        vld_p1;

    // Wraps modulo 2^32 naturally: 32'hFFFF_FFFC + 4 = 0.
    assign pc_plus4      = pc_p0 + 32'd4;
    // Masking (rather than slicing) keeps every address bit in use.
    assign branch_target = branch_address & 32'hFFFF_FFFC;

    // ---- stage p0: program counter (IF) ----
    // Branch beats freeze: the frozen instruction in ID is squashed anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0 <= RESET_PC;
        end else if (branch_taken) begin
            pc_p0 <= branch_target;
        end else if (!hazard_detected) begin
            pc_p0 <= pc_plus4;
        end
    end

    assign imem_addr = pc_p0;

    // ---- stage p1: IF/ID register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1 <= 32'd0;
            pc_p1    <= 32'd0;
            vld_p1   <= 1'b0;
        end else if (branch_taken) begin
            instr_p1 <= 32'd0;
            pc_p1    <= 32'd0;
            vld_p1   <= 1'b0;
        end else if (!hazard_detected) begin
            instr_p1 <= imem_rdata;
            pc_p1    <= pc_plus4;
            vld_p1   <= 1'b1;
        end
    end

    assign if_id_instr = instr_p1;
    assign if_id_pc    = pc_p1;
    assign if_id_valid = vld_p1;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: every state follows the same priority, so RESET_FILL
    // leaves on its first edge and REDIRECT repeats while branch_taken stays high.
    always_comb begin
        state_d = RUN;
        if (branch_taken) begin
            state_d = REDIRECT;
        end else if (hazard_detected) begin
            state_d = STALL;
        end
    end

    // FSM outputs
    always_comb begin
        fetch_state = state_q;
    end

`ifdef STALL_COUNTER_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // A freeze overridden by a branch is not counted as a stall cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (hazard_detected && !branch_taken) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
            if (branch_taken) begin
                flush_cnt_q <= sat_inc16(flush_cnt_q);
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. The instruction memory returns word =
// address. Each check packs {imem_addr, if_id_instr, if_id_pc, if_id_valid,
// fetch_state} and compares the packed value against a hand-computed
// expectation. Counter checks exist only when STALL_COUNTER_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        hazard_detected;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [1:0]  fetch_state;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_count;
    logic [15:0] flush_count;
`endif

    int n_cmp;
    int n_fail;

    logic [98:0] got;
    logic [98:0] exp;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid),
        .fetch_state     (fetch_state)
`ifdef STALL_COUNTER_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    // Combinational memory: word = address
    assign imem_rdata = imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [98:0] snap();
        return {imem_addr, if_id_instr, if_id_pc, if_id_valid, fetch_state};
    endfunction

    // Advance one rising edge and settle; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0;
        branch_address = 32'd0;
        #1;
        got = snap(); exp = {32'h0, 32'h0, 32'h0, 1'b0, 2'd0}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset got=%h exp=%h", got, exp); end
`ifdef STALL_COUNTER_EN
        n_cmp++;
        if ({stall_count, flush_count} !== 48'd0) begin
            n_fail++; $display("FAIL reset_cnt got=%h exp=0", {stall_count, flush_count});
        end
`endif
        #1 rst_n = 1'b1;
    endtask

    task automatic test_fill();
        step();
        got = snap(); exp = {32'h4, 32'h0, 32'h4, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL fill_e1 got=%h exp=%h", got, exp); end
        step();
        got = snap(); exp = {32'h8, 32'h4, 32'h8, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL fill_e2 got=%h exp=%h", got, exp); end
        step();
        got = snap(); exp = {32'hC, 32'h8, 32'hC, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL fill_e3 got=%h exp=%h", got, exp); end
        step();
        got = snap(); exp = {32'h10, 32'hC, 32'h10, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL fill_e4 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_stall();
        hazard_detected = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = snap(); exp = {32'h10, 32'hC, 32'h10, 1'b1, 2'd2}; n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL stall_%0d got=%h exp=%h", i, got, exp); end
        end
`ifdef STALL_COUNTER_EN
        n_cmp++;
        if (stall_count !== 32'd3) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=3", stall_count); end
`endif
        hazard_detected = 1'b0;
        step();
        got = snap(); exp = {32'h14, 32'h10, 32'h14, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL stall_release got=%h exp=%h", got, exp); end
    endtask

    task automatic test_branch();
        step(); step(); step();
        got = snap(); exp = {32'h20, 32'h1C, 32'h20, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL pre_branch got=%h exp=%h", got, exp); end
        branch_taken = 1'b1; branch_address = 32'h103;
        step();
        got = snap(); exp = {32'h100, 32'h0, 32'h0, 1'b0, 2'd3}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL branch_bubble got=%h exp=%h", got, exp); end
`ifdef STALL_COUNTER_EN
        n_cmp++;
        if (flush_count !== 16'd1) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=1", flush_count); end
`endif
        branch_taken = 1'b0; branch_address = 32'd0;
        step();
        got = snap(); exp = {32'h104, 32'h100, 32'h104, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL branch_target got=%h exp=%h", got, exp); end
    endtask

    task automatic test_branch_and_hazard();
        branch_taken = 1'b1; hazard_detected = 1'b1; branch_address = 32'h40;
        step();
        got = snap(); exp = {32'h40, 32'h0, 32'h0, 1'b0, 2'd3}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL br_hz got=%h exp=%h", got, exp); end
`ifdef STALL_COUNTER_EN
        n_cmp++;
        if ({stall_count, flush_count} !== {32'd3, 16'd2}) begin
            n_fail++; $display("FAIL br_hz_cnt got=%h exp=%h", {stall_count, flush_count}, {32'd3, 16'd2});
        end
`endif
        branch_taken = 1'b0; hazard_detected = 1'b0;
        step();
        got = snap(); exp = {32'h44, 32'h40, 32'h44, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL br_hz_after got=%h exp=%h", got, exp); end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFE;
        step();
        got = snap(); exp = {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 2'd3}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_load got=%h exp=%h", got, exp); end
        branch_taken = 1'b0;
        step();
        got = snap(); exp = {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap got=%h exp=%h", got, exp); end
    endtask

    task automatic test_back_to_back_redirect();
        branch_taken = 1'b1; branch_address = 32'h80;
        for (int i = 0; i < 2; i++) begin
            step();
            got = snap(); exp = {32'h80, 32'h0, 32'h0, 1'b0, 2'd3}; n_cmp++;
            if (got !== exp) begin n_fail++; $display("FAIL redirect_hold_%0d got=%h exp=%h", i, got, exp); end
        end
`ifdef STALL_COUNTER_EN
        n_cmp++;
        if (flush_count !== 16'd5) begin n_fail++; $display("FAIL flush_cnt5 got=%0d exp=5", flush_count); end
`endif
    endtask

    task automatic test_async_reset();
        branch_taken = 1'b0; hazard_detected = 1'b1;
        step();
        got = snap(); exp = {32'h80, 32'h0, 32'h0, 1'b0, 2'd2}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL pre_rst_stall got=%h exp=%h", got, exp); end
        #2 rst_n = 1'b0;
        #1;
        got = snap(); exp = {32'h0, 32'h0, 32'h0, 1'b0, 2'd0}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL async_rst got=%h exp=%h", got, exp); end
`ifdef STALL_COUNTER_EN
        n_cmp++;
        if ({stall_count, flush_count} !== 48'd0) begin
            n_fail++; $display("FAIL async_rst_cnt got=%h exp=0", {stall_count, flush_count});
        end
`endif
        hazard_detected = 1'b0;
        #1 rst_n = 1'b1;
        step();
        got = snap(); exp = {32'h4, 32'h0, 32'h4, 1'b1, 2'd1}; n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL post_rst got=%h exp=%h", got, exp); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_fill();
        test_stall();
        test_branch();
        test_branch_and_hazard();
        test_wrap();
        test_back_to_back_redirect();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
